ball_controller: RTL

Per-frame motion sequencer for the bouncing ball. It watches the vertical blanking signal from the VGA timing generator and, once per frame while the beam is blanked, runs a short state machine that advances the ball position, reflects it off the visible-area edges and commits the new position. It also produces the ball's pixel-enable from the timing generator's H/V counters; that signal feeds the timing generator's `i_Video`.

---
 rtl/ball_controller.sv | 138 +++++++++++++
 1 files changed

// File: rtl/ball_controller.sv
// Per-frame bouncing-ball sequencer: steps, reflects and commits the ball once per VBlank, plus the ball pixel-enable.
// Optional: define BALL_FRAME_DIV_EN to update only every P_FRAME_DIV-th enabled frame.
module ball_controller #(
  parameter int P_H_VISIBLE = 640,
  parameter int P_V_VISIBLE = 480,
  parameter int P_SIZE      = 16,
  parameter int P_STEP      = 2,
  parameter int P_X0        = 1,
  parameter int P_Y0        = 1,
  parameter int P_FRAME_DIV = 2
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_VBlank,
  input  logic       i_Enable,
  input  logic [9:0] i_HPos,
  input  logic [9:0] i_VPos,
  output logic [9:0] o_BallX,
  output logic [9:0] o_BallY,
  output logic       o_Video,
  output logic       o_Busy,
  output logic       o_Bounce
);

  typedef enum logic [1:0] {IDLE, STEP_X, STEP_Y, COMMIT} state_t;

  localparam logic signed [10:0] STEP_S = 11'(P_STEP);
  localparam logic signed [10:0] X_MAX  = 11'(P_H_VISIBLE - P_SIZE + 1);
  localparam logic signed [10:0] Y_MAX  = 11'(P_V_VISIBLE - P_SIZE + 1);
  localparam logic signed [10:0] ONE_S  = 11'sd1;
  localparam logic [10:0]        SIZE_U = 11'(P_SIZE);

  state_t state, state_nxt;
  logic   vblank_q, trig, start;
  logic   dir_x, dir_y, bounce_flag;
  logic signed [10:0] x_w, y_w, x_sum, y_sum;

  assign trig = i_VBlank & ~vblank_q & i_Enable & (state == IDLE);

`ifdef BALL_FRAME_DIV_EN
  localparam int FW = $clog2(P_FRAME_DIV) + 1;
  logic [FW-1:0] frame_cnt;

  // Counter at 0 means this trigger is the one that runs an update.
  assign start = trig & (frame_cnt == '0);

  always_ff @(posedge i_Clk) begin
    if (i_Reset)
      frame_cnt <= '0;
    else if (trig)
      frame_cnt <= (frame_cnt == FW'(P_FRAME_DIV - 1)) ? '0 : frame_cnt + 1'b1;
  end
`else
  assign start = trig;
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = STEP_X;
      STEP_X:  state_nxt = STEP_Y;
      STEP_Y:  state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_Busy = (state != IDLE);
  end

  assign x_sum = dir_x ? x_w + STEP_S : x_w - STEP_S;
  assign y_sum = dir_y ? y_w + STEP_S : y_w - STEP_S;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      vblank_q    <= 1'b0;
      x_w         <= 11'(P_X0);
      y_w         <= 11'(P_Y0);
      dir_x       <= 1'b1;
      dir_y       <= 1'b1;
      bounce_flag <= 1'b0;
      o_BallX     <= 10'(P_X0);
      o_BallY     <= 10'(P_Y0);
      o_Bounce    <= 1'b0;
    end else begin
      vblank_q <= i_VBlank;
      o_Bounce <= 1'b0;
      case (state)
        STEP_X: begin
          if (x_sum > X_MAX) begin
            x_w <= X_MAX; dir_x <= 1'b0; bounce_flag <= 1'b1;
          end else if (x_sum < ONE_S) begin
            x_w <= ONE_S; dir_x <= 1'b1; bounce_flag <= 1'b1;
          end else begin
            x_w <= x_sum;
          end
        end
        STEP_Y: begin
          if (y_sum > Y_MAX) begin
            y_w <= Y_MAX; dir_y <= 1'b0; bounce_flag <= 1'b1;
          end else if (y_sum < ONE_S) begin
            y_w <= ONE_S; dir_y <= 1'b1; bounce_flag <= 1'b1;
          end else begin
            y_w <= y_sum;
          end
        end
        // A corner hit sets the flag twice but still yields one pulse.
        COMMIT: begin
          o_BallX     <= x_w[9:0];
          o_BallY     <= y_w[9:0];
          o_Bounce    <= bounce_flag;
          bounce_flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  logic [10:0] hx, vy, bx, by;
  assign hx = {1'b0, i_HPos};
  assign vy = {1'b0, i_VPos};
  assign bx = {1'b0, o_BallX};
  assign by = {1'b0, o_BallY};

  always_ff @(posedge i_Clk) begin
    if (i_Reset)
      o_Video <= 1'b0;
    else
      o_Video <= (hx >= bx) && (hx < bx + SIZE_U) && (vy >= by) && (vy < by + SIZE_U);
  end

endmodule
